// File: rtl/ins_fetch_if.sv
// ----------------------------------------------------------------------------
// ins_fetch_if
// Bundle of the control, BRAM and issue signals of the instruction fetch unit.
//
// Handshake: ins_valid/stall form a valid-with-backpressure pair. When
// ins_valid is high, ins_out and pc are stable. The instruction transfers on
// the first rising edge where ins_valid=1 and stall=0. While stall=1 the
// producer holds ins_valid, ins_out and pc unchanged.
//
// Signals
//   start, start_pc  : program launch request (sampled only when idle)
//   stall            : downstream back-pressure
//   ins_bram_addr    : instruction BRAM read address (driven by fetch unit)
//   ins_bram_dout    : instruction BRAM read data
//   ins_out/ins_valid: issued instruction word and its valid flag
//   pc, busy, done, pc_wrapped, issue_count : status
//
// Modports
//   master : controller/BRAM/consumer side
//   slave  : the fetch unit
// ----------------------------------------------------------------------------
interface ins_fetch_if #(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_BRAM_WIDTH = 64
);
  logic                      start;
  logic [INS_ADDR_WIDTH-1:0] start_pc;
  logic                      stall;
  logic [INS_BRAM_WIDTH-1:0] ins_bram_dout;
  logic [INS_ADDR_WIDTH-1:0] ins_bram_addr;
  logic [INS_BRAM_WIDTH-1:0] ins_out;
  logic                      ins_valid;
  logic [INS_ADDR_WIDTH-1:0] pc;
  logic                      busy;
  logic                      done;
  logic                      pc_wrapped;
  logic [15:0]               issue_count;

  modport master (
    output start, start_pc, stall, ins_bram_dout,
    input  ins_bram_addr, ins_out, ins_valid, pc, busy, done, pc_wrapped,
           issue_count
  );

  modport slave (
    input  start, start_pc, stall, ins_bram_dout,
    output ins_bram_addr, ins_out, ins_valid, pc, busy, done, pc_wrapped,
           issue_count
  );
endinterface

// File: rtl/ins_fetch_unit.sv
// ----------------------------------------------------------------------------
// ins_fetch_unit
// Fetches instruction words from an instruction BRAM starting at start_pc and
// issues them downstream one every ISSUE_INTERVAL cycles (when not stalled).
// A word whose opcode field equals HALT_OPCODE ends the program: nothing is
// issued for it, the unit waits DRAIN_CYCLES for the downstream pipeline to
// finish, pulses done for one cycle and returns to idle.
//
// Ports
//   clk         : system clock, rising edge
//   rstn        : asynchronous active-low reset
//   fetch_bus   : ins_fetch_if.slave (start/stall in, BRAM bus, issue, status)
//   o_dbg_state : current FSM state encoding (state_t)
//
// Parameter constraints: BRAM_LATENCY >= 1,
// ISSUE_INTERVAL >= BRAM_LATENCY+1, DRAIN_CYCLES >= 1, all below 2^16.
// ----------------------------------------------------------------------------
module ins_fetch_unit #(
  parameter int                      INS_ADDR_WIDTH = 8,
  parameter int                      INS_BRAM_WIDTH = 64,
  parameter int                      ADDR_WIDTH     = 10,
  parameter int                      OPCODE_WIDTH   = 4,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE    = '1,
  parameter int                      BRAM_LATENCY   = 1,
  parameter int                      ISSUE_INTERVAL = 2,
  parameter int                      DRAIN_CYCLES   = 6
) (
  input  logic              clk,
  input  logic              rstn,
  ins_fetch_if.slave        fetch_bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Cycles spent in WAIT between a completed issue and the next FETCH.
  localparam int          WAIT_CYCLES = ISSUE_INTERVAL - BRAM_LATENCY - 1;
  localparam logic [15:0] FETCH_LAST  = 16'(BRAM_LATENCY - 1);
  localparam logic [15:0] WAIT_LAST   = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [15:0]               r_cnt;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic [INS_BRAM_WIDTH-1:0] r_ins_out;
  logic                      r_pc_wrapped;
  logic [15:0]               r_issue_count;

  logic [OPCODE_WIDTH-1:0]   w_opcode;
  logic                      w_is_halt;
  logic                      w_start_ok;
  logic                      w_fetch_done;
  logic                      w_issue_done;
  logic                      w_cnt_run;

  assign w_opcode     = fetch_bus.ins_bram_dout[3*ADDR_WIDTH +: OPCODE_WIDTH];
  assign w_is_halt    = (w_opcode == HALT_OPCODE);
  assign w_start_ok   = (r_state == S_IDLE) && fetch_bus.start;
  // The BRAM word is sampled on the last cycle of the FETCH hold window.
  assign w_fetch_done = (r_state == S_FETCH) && (r_cnt == FETCH_LAST);
  assign w_issue_done = (r_state == S_ISSUE) && !fetch_bus.stall;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (fetch_bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_fetch_done) w_next = w_is_halt ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: begin
        if (!fetch_bus.stall) w_next = (WAIT_CYCLES == 0) ? S_FETCH : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == WAIT_LAST) w_next = S_FETCH;
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Only the timed states count; every state entry restarts the counter.
  assign w_cnt_run = (r_state == S_FETCH) || (r_state == S_WAIT) ||
                     (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!w_cnt_run || (w_next != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc          <= '0;
      r_ins_out     <= '0;
      r_pc_wrapped  <= 1'b0;
      r_issue_count <= '0;
    end else begin
      if (w_start_ok) begin
        r_pc          <= fetch_bus.start_pc;
        r_pc_wrapped  <= 1'b0;
        r_issue_count <= '0;
      end
      if (w_fetch_done && !w_is_halt) begin
        r_ins_out <= fetch_bus.ins_bram_dout;
      end
      if (w_issue_done) begin
        // pc advances modulo 2^INS_ADDR_WIDTH; a wrap is remembered.
        r_pc <= r_pc + 1'b1;
        if (r_pc == '1) r_pc_wrapped <= 1'b1;
        if (r_issue_count != 16'hFFFF) r_issue_count <= r_issue_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign fetch_bus.ins_bram_addr = r_pc;
  assign fetch_bus.pc            = r_pc;
  assign fetch_bus.ins_out       = r_ins_out;
  assign fetch_bus.ins_valid     = (r_state == S_ISSUE);
  assign fetch_bus.busy          = (r_state != S_IDLE);
  assign fetch_bus.done          = (r_state == S_DONE);
  assign fetch_bus.pc_wrapped    = r_pc_wrapped;
  assign fetch_bus.issue_count   = r_issue_count;
  assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ins_fetch_unit
// Directed bench for ins_fetch_unit with default parameters. The instruction
// BRAM model returns mem[addr] to be sampled at the next rising edge
// (BRAM_LATENCY = 1). Normal words carry their own address in the low byte
// and opcode 0; halt words have opcode 4'hF in bits [33:30].
// ----------------------------------------------------------------------------
module tb_ins_fetch_unit;

  localparam logic [63:0] NORM_BASE = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] HALT_BITS = 64'h0000_0003_C000_0000; // opcode F
  localparam logic [63:0] OPC_E     = 64'h0000_0003_8000_0000; // opcode E

  // -------------------------------------------------- clock / reset
  logic clk;
  logic rstn;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ins_fetch_if #(.INS_ADDR_WIDTH(8), .INS_BRAM_WIDTH(64)) bus ();

  ins_fetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_bus   (bus),
    .o_dbg_state (dbg_state)
  );

  logic [63:0] mem [0:255];
  assign bus.ins_bram_dout = mem[bus.ins_bram_addr];

  // -------------------------------------------------- scoreboard
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_init();
    for (int i = 0; i < 256; i++) mem[i] = NORM_BASE | 64'(i);
  endtask

  // -------------------------------------------------- driver
  // Pulses start for the cycle labelled 0, then runs ncyc cycles. In cycle c
  // stall = smask[c]; start = xmask[c] (with a bogus start_pc). Each cycle
  // checks ins_valid against vmask[c], done against dmask[c] and busy (high up
  // to and including the done cycle); every valid cycle checks ins_out/pc
  // against the head of exp_q, which pops on an unstalled issue.
  task automatic run_prog(input string tag, input logic [7:0] spc,
                          input int ncyc, input logic [31:0] vmask,
                          input logic [31:0] dmask, input logic [31:0] smask,
                          input logic [31:0] xmask);
    logic [31:0] dm;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.start_pc = spc;
    bus.stall    = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.start    = xmask[c];
      bus.start_pc = xmask[c] ? 8'h55 : spc;
      bus.stall    = smask[c];
      #1;
      dm = dmask >> c;
      chk_eq($sformatf("%s c%0d valid", tag, c), 64'(bus.ins_valid), 64'(vmask[c]));
      chk_eq($sformatf("%s c%0d done", tag, c), 64'(bus.done), 64'(dmask[c]));
      chk_eq($sformatf("%s c%0d busy", tag, c), 64'(bus.busy), 64'(|dm));
      if (c == 1)
        chk_eq($sformatf("%s addr", tag), 64'(bus.ins_bram_addr), 64'(spc));
      if (bus.ins_valid) begin
        if (exp_q.size() == 0) begin
          chk_eq($sformatf("%s c%0d extra valid", tag, c), 64'(bus.ins_valid), 64'd0);
        end else begin
          chk_eq($sformatf("%s c%0d ins_out", tag, c), bus.ins_out, exp_q[0]);
          chk_eq($sformatf("%s c%0d pc", tag, c), 64'(bus.pc), 64'(exp_q[0][7:0]));
          if (!bus.stall) void'(exp_q.pop_front());
        end
      end
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    chk_eq($sformatf("%s left in queue", tag), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, " state"}, 64'(dbg_state), 64'd0);
    chk_eq({tag, " pc"}, 64'(bus.pc), 64'd0);
    chk_eq({tag, " addr"}, 64'(bus.ins_bram_addr), 64'd0);
    chk_eq({tag, " ins_out"}, bus.ins_out, 64'd0);
    chk_eq({tag, " valid"}, 64'(bus.ins_valid), 64'd0);
    chk_eq({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk_eq({tag, " done"}, 64'(bus.done), 64'd0);
    chk_eq({tag, " wrapped"}, 64'(bus.pc_wrapped), 64'd0);
    chk_eq({tag, " count"}, 64'(bus.issue_count), 64'd0);
  endtask

  // -------------------------------------------------- stimulus
  initial begin
    rstn         = 1'b0;
    bus.start    = 1'b0;
    bus.start_pc = 8'h00;
    bus.stall    = 1'b0;
    mem_init();
    mem[8'h11] = NORM_BASE | OPC_E | 64'h11;   // opcode E is not halt
    mem[8'h12] = HALT_BITS | 64'h12;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rstn = 1'b1;

    // Two ops then halt: valid at 2 and 4, done at 12.
    exp_q.push_back(mem[8'h10]);
    exp_q.push_back(mem[8'h11]);
    run_prog("basic", 8'h10, 13, 32'h0000_0014, 32'h0000_1000, 32'h0, 32'h0);
    chk_eq("basic count", 64'(bus.issue_count), 64'd2);
    chk_eq("basic wrapped", 64'(bus.pc_wrapped), 64'd0);
    chk_eq("basic pc", 64'(bus.pc), 64'h12);

    // Stall cycles 2..4: valid held 2..5, second issue at 7, done at 15.
    exp_q.push_back(mem[8'h10]);
    exp_q.push_back(mem[8'h11]);
    run_prog("stall", 8'h10, 16, 32'h0000_00BC, 32'h0000_8000, 32'h0000_001C, 32'h0);
    chk_eq("stall count", 64'(bus.issue_count), 64'd2);

    // Wrap: issue 0xFF, halt at 0x00, done at 10.
    mem[8'h00] = HALT_BITS;
    exp_q.push_back(mem[8'hFF]);
    run_prog("wrap", 8'hFF, 11, 32'h0000_0004, 32'h0000_0400, 32'h0, 32'h0);
    chk_eq("wrap count", 64'(bus.issue_count), 64'd1);
    chk_eq("wrap wrapped", 64'(bus.pc_wrapped), 64'd1);
    chk_eq("wrap pc", 64'(bus.pc), 64'h00);
    repeat (3) @(negedge clk);
    chk_eq("idle hold wrapped", 64'(bus.pc_wrapped), 64'd1);
    chk_eq("idle hold count", 64'(bus.issue_count), 64'd1);

    // Halt first: no valid, done at 8.
    mem[8'h40] = HALT_BITS | 64'h40;
    run_prog("halt1st", 8'h40, 9, 32'h0, 32'h0000_0100, 32'h0, 32'h0);
    chk_eq("halt1st count", 64'(bus.issue_count), 64'd0);
    chk_eq("halt1st wrapped", 64'(bus.pc_wrapped), 64'd0);

    // Start pulses while busy (cycles 2, 3 and in DONE at 12) are ignored.
    exp_q.push_back(mem[8'h10]);
    exp_q.push_back(mem[8'h11]);
    run_prog("busystart", 8'h10, 14, 32'h0000_0014, 32'h0000_1000, 32'h0, 32'h0000_100C);
    chk_eq("busystart count", 64'(bus.issue_count), 64'd2);

    // Reset mid-run, after the first issue.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.start_pc = 8'h10;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    chk_eq("pre-reset count", 64'(bus.issue_count), 64'd1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_eq($sformatf("midrst hold%0d done", c), 64'(bus.done), 64'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk_eq("after release state", 64'(dbg_state), 64'd0);
    chk_eq("after release done", 64'(bus.done), 64'd0);

    // Restart runs normally.
    exp_q.push_back(mem[8'h10]);
    exp_q.push_back(mem[8'h11]);
    run_prog("restart", 8'h10, 13, 32'h0000_0014, 32'h0000_1000, 32'h0, 32'h0);
    chk_eq("restart count", 64'(bus.issue_count), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
